tx_resp_arbiter: RTL and testbench
==================================

Name: tx_resp_arbiter

Overview:
- Shares the single TX FIFO write port between the two response sources of the system controller path: register-file read data (1 byte) and ALU results (2 bytes).
- Round-robin arbitration; an ALU result is always written as an atomic low-byte/high-byte pair.
- Sits between the controller/RF/ALU and the async TX FIFO write side.

Parameters:
- DATA_WIDTH, 8, FIFO word width; ALU result width is 2*DATA_WIDTH.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-low
- RF_REQ  in  1  RF response pending; held high with RF_DATA stable until RF_ACK
- RF_DATA  in  DATA_WIDTH  RF read byte
- RF_ACK  out  1  one-cycle pulse: RF_DATA captured
- ALU_REQ  in  1  ALU result pending; held high with ALU_DATA stable until ALU_ACK
- ALU_DATA  in  2*DATA_WIDTH  ALU result
- ALU_ACK  out  1  one-cycle pulse: ALU_DATA captured
- FIFO_FULL  in  1  TX FIFO full
- WR_INC  out  1  FIFO write strobe
- WR_DATA  out  DATA_WIDTH  FIFO write data
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Single clock domain. Reset is sampled on the rising CLK edge when RST=0.
- Reset values:
  - State = IDLE.
  - RF_ACK, ALU_ACK, WR_INC, BUSY = 0; WR_DATA = 0.
  - Capture registers = 0.
  - Last-grant pointer = ALU, so RF wins the first tie.
- States: IDLE, SEND_RF, SEND_LO, SEND_HI (plus SEND_HDR when the optional feature is enabled).
- IDLE:
  - With no request, stay in IDLE.
  - With one request, grant it.
  - With both requests, grant the requester opposite the last-grant pointer.
  - On grant at edge N:
    - capture the data (RF byte, or full ALU word);
    - update the pointer;
    - pulse the matching ACK high for exactly cycle N+1 (registered);
    - move to SEND_RF or SEND_LO.
- SEND_* states:
  - WR_INC = !FIFO_FULL (combinational). WR_DATA = the byte for the current state, from the capture register.
  - While FIFO_FULL=1: WR_INC=0; hold state and data indefinitely.
  - SEND_RF, on write: go to IDLE.
  - SEND_LO, on write: WR_DATA=ALU[DATA_WIDTH-1:0]; go to SEND_HI.
  - SEND_HI, on write: WR_DATA=ALU[2*DATA_WIDTH-1:DATA_WIDTH]; go to IDLE.
- Outside SEND_* states WR_INC=0 and WR_DATA=0.
- Arbitration happens only in IDLE, so there is at least one IDLE cycle between packets.
  - Minimum RF packet: 2 cycles (IDLE grant + SEND_RF).
  - Minimum ALU packet: 3 cycles.
- A request arriving mid-packet is held by the requester and served after return to IDLE.
- ALU high byte always directly follows its low byte; no RF byte is interleaved.
- A request dropped before grant is ignored (requester protocol violation; no ACK issued).
- REQ still high in the cycle of its ACK is not regranted. The arbiter ignores a requester's REQ in the cycle after its ACK, so a held REQ does not double-grant.
- Reset mid-packet: all outputs return to reset values on that edge. Remaining bytes are discarded; no partial ALU pair is completed.
- Back-to-back FIFO_FULL toggling: each write occurs only in a cycle with FIFO_FULL=0. No byte is duplicated or skipped.

Optional Feature:
- Macro: TX_HDR_EN.
- Defined:
  - After grant, state SEND_HDR first writes one tag byte: 8'hBB for RF packets, 8'hCC for ALU packets. It obeys the same FIFO_FULL stall rule, then proceeds to SEND_RF or SEND_LO.
  - Packet sizes become 2 and 3 bytes.
- Undefined: SEND_HDR state and tag logic are absent; behaviour exactly as above.

Test Plan:
- RF_REQ=1, RF_DATA=8'h5A, FIFO_FULL=0:
  - RF_ACK pulses one cycle after grant.
  - Next cycle WR_INC=1 with WR_DATA=8'h5A.
  - BUSY returns to 0.
- ALU_REQ=1, ALU_DATA=16'h1234:
  - Two consecutive writes, 8'h34 then 8'h12.
  - ALU_ACK pulses once.
- RF_REQ and ALU_REQ both rise together, held until ACK:
  - First grant RF (reset pointer).
  - FIFO order: RF byte, 8'h34, 8'h12.
  - Re-raise both: the ALU pair now precedes RF.
- ALU 16'hABCD with FIFO_FULL=1 for 5 cycles during SEND_HI:
  - 8'hCD written, then WR_INC=0 for 5 cycles with WR_DATA=8'hAB.
  - Then exactly one write of 8'hAB.
- RST=0 for one edge while in SEND_HI:
  - Next cycle: IDLE, WR_INC=0, BUSY=0.
  - 8'hAB never written.
- With TX_HDR_EN, RF 8'h07 then ALU 16'h0102:
  - FIFO receives BB,07,CC,02,01.

Source files
------------

// File: rtl/tx_resp_arbiter.sv
// tx_resp_arbiter: round-robin sharing of the TX FIFO write port between the
// register-file read byte and the two-byte ALU result.
// An ALU result is always written as an unbroken low/high byte pair.
// Optional macro TX_HDR_EN: each packet is preceded by a tag byte
// (BB for RF, CC for ALU).
module tx_resp_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RF_REQ,
  input  logic [DATA_WIDTH-1:0]   RF_DATA,
  output logic                    RF_ACK,
  input  logic                    ALU_REQ,
  input  logic [2*DATA_WIDTH-1:0] ALU_DATA,
  output logic                    ALU_ACK,
  input  logic                    FIFO_FULL,
  output logic                    WR_INC,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    BUSY
);

`ifdef TX_HDR_EN
  typedef enum logic [2:0] {IDLE, SEND_RF, SEND_LO, SEND_HI, SEND_HDR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND_RF, SEND_LO, SEND_HI} state_t;
`endif

  state_t                  state;
  logic [DATA_WIDTH-1:0]   rf_cap;
  logic [2*DATA_WIDTH-1:0] alu_cap;
  logic                    last_alu;   // last grant went to the ALU
  logic                    rf_ack_d;   // RF_ACK was high last cycle
  logic                    alu_ack_d;  // ALU_ACK was high last cycle
`ifdef TX_HDR_EN
  logic                    hdr_alu;    // packet behind the tag is an ALU pair
`endif

  // A REQ still held in the cycle after its ACK belongs to the packet just
  // granted, so it is masked to prevent a double grant.
  logic rf_ok, alu_ok, grant_rf, grant_alu;
  assign rf_ok     = RF_REQ  && !rf_ack_d;
  assign alu_ok    = ALU_REQ && !alu_ack_d;
  assign grant_rf  = rf_ok && (!alu_ok || last_alu);
  assign grant_alu = alu_ok && !grant_rf;

  // Write port: strobe follows FIFO_FULL combinationally in the SEND states.
  // A cycle with reset asserted never writes, so a reset mid-packet cannot
  // leak the byte that was pending.
  always_comb begin
    WR_INC  = 1'b0;
    WR_DATA = '0;
    case (state)
      SEND_RF: begin
        WR_INC  = RST && !FIFO_FULL;
        WR_DATA = rf_cap;
      end
      SEND_LO: begin
        WR_INC  = RST && !FIFO_FULL;
        WR_DATA = alu_cap[DATA_WIDTH-1:0];
      end
      SEND_HI: begin
        WR_INC  = RST && !FIFO_FULL;
        WR_DATA = alu_cap[2*DATA_WIDTH-1:DATA_WIDTH];
      end
`ifdef TX_HDR_EN
      SEND_HDR: begin
        WR_INC  = RST && !FIFO_FULL;
        WR_DATA = hdr_alu ? DATA_WIDTH'(8'hCC) : DATA_WIDTH'(8'hBB);
      end
`endif
      default: ;
    endcase
  end

  // Arbitration FSM with registered ACK pulses and BUSY.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      rf_cap    <= '0;
      alu_cap   <= '0;
      last_alu  <= 1'b1;
      rf_ack_d  <= 1'b0;
      alu_ack_d <= 1'b0;
      RF_ACK    <= 1'b0;
      ALU_ACK   <= 1'b0;
      BUSY      <= 1'b0;
`ifdef TX_HDR_EN
      hdr_alu   <= 1'b0;
`endif
    end else begin
      RF_ACK    <= 1'b0;
      ALU_ACK   <= 1'b0;
      rf_ack_d  <= RF_ACK;
      alu_ack_d <= ALU_ACK;
      case (state)
        IDLE: begin
          if (grant_rf) begin
            rf_cap   <= RF_DATA;
            last_alu <= 1'b0;
            RF_ACK   <= 1'b1;
            BUSY     <= 1'b1;
`ifdef TX_HDR_EN
            hdr_alu  <= 1'b0;
            state    <= SEND_HDR;
`else
            state    <= SEND_RF;
`endif
          end else if (grant_alu) begin
            alu_cap  <= ALU_DATA;
            last_alu <= 1'b1;
            ALU_ACK  <= 1'b1;
            BUSY     <= 1'b1;
`ifdef TX_HDR_EN
            hdr_alu  <= 1'b1;
            state    <= SEND_HDR;
`else
            state    <= SEND_LO;
`endif
          end
        end
        SEND_RF: begin
          if (!FIFO_FULL) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        SEND_LO: begin
          if (!FIFO_FULL) state <= SEND_HI;
        end
        SEND_HI: begin
          if (!FIFO_FULL) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
`ifdef TX_HDR_EN
        SEND_HDR: begin
          if (!FIFO_FULL) state <= hdr_alu ? SEND_LO : SEND_RF;
        end
`endif
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Directed bench for tx_resp_arbiter (default build, no tag bytes).
// Each vector is one clock cycle: inputs driven just after the rising edge,
// outputs compared at the falling edge; FIFO writes are logged separately
// and compared against the expected byte stream at the end.
module tb_tx_resp_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RF_REQ;
  logic [7:0]  RF_DATA;
  logic        RF_ACK;
  logic        ALU_REQ;
  logic [15:0] ALU_DATA;
  logic        ALU_ACK;
  logic        FIFO_FULL;
  logic        WR_INC;
  logic [7:0]  WR_DATA;
  logic        BUSY;

  tx_resp_arbiter #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .RF_REQ(RF_REQ), .RF_DATA(RF_DATA), .RF_ACK(RF_ACK),
    .ALU_REQ(ALU_REQ), .ALU_DATA(ALU_DATA), .ALU_ACK(ALU_ACK),
    .FIFO_FULL(FIFO_FULL), .WR_INC(WR_INC), .WR_DATA(WR_DATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        rf_req;
    logic [7:0]  rf_data;
    logic        alu_req;
    logic [15:0] alu_data;
    logic        full;
    logic        e_rf_ack;
    logic        e_alu_ack;
    logic        e_wr;
    logic [7:0]  e_data;
    logic        e_busy;
  } vec_t;

  int         n_run  = 0;
  int         n_fail = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  vec_t       tbl[$];

  // FIFO sink: log every accepted write
  always @(negedge CLK) if (WR_INC === 1'b1) got_q.push_back(WR_DATA);

  function automatic vec_t mk(logic rst, logic rfq, logic [7:0] rfd, logic aluq,
                              logic [15:0] alud, logic full, logic era, logic eaa,
                              logic ewr, logic [7:0] ed, logic eb);
    vec_t v;
    v.rst = rst; v.rf_req = rfq; v.rf_data = rfd; v.alu_req = aluq;
    v.alu_data = alud; v.full = full; v.e_rf_ack = era; v.e_alu_ack = eaa;
    v.e_wr = ewr; v.e_data = ed; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [15:0] got, logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx);
    RST = v.rst; RF_REQ = v.rf_req; RF_DATA = v.rf_data;
    ALU_REQ = v.alu_req; ALU_DATA = v.alu_data; FIFO_FULL = v.full;
    @(negedge CLK);
    chk("rf_ack",  idx, 16'(RF_ACK),  16'(v.e_rf_ack));
    chk("alu_ack", idx, 16'(ALU_ACK), 16'(v.e_alu_ack));
    chk("wr_inc",  idx, 16'(WR_INC),  16'(v.e_wr));
    chk("wr_data", idx, 16'(WR_DATA), 16'(v.e_data));
    chk("busy",    idx, 16'(BUSY),    16'(v.e_busy));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //               rst rfq rfd   aq alud     full  rfa ala wr data  busy
    // reset
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(0, 1, 8'h11, 1, 16'h2222, 0,   0, 0, 0, 8'h00, 0));
    // both together: reset pointer gives RF first, then the ALU pair
    tbl.push_back(mk(1, 1, 8'h5A, 1, 16'h1234, 0,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h5A, 1, 16'h1234, 0,   1, 0, 1, 8'h5A, 1));
    tbl.push_back(mk(1, 1, 8'h5A, 1, 16'h1234, 0,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 8'h5A, 1, 16'h1234, 0,   0, 1, 1, 8'h34, 1));
    tbl.push_back(mk(1, 0, 8'h5A, 0, 16'h1234, 0,   0, 0, 1, 8'h12, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
    // RF alone, REQ held one cycle past ACK must not regrant
    tbl.push_back(mk(1, 1, 8'h5A, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h5A, 0, 16'h0000, 0,   1, 0, 1, 8'h5A, 1));
    tbl.push_back(mk(1, 1, 8'h5A, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 8'h5A, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
    // both again with pointer at RF: ALU pair precedes RF
    tbl.push_back(mk(1, 1, 8'h77, 1, 16'h1234, 0,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h77, 1, 16'h1234, 0,   0, 1, 1, 8'h34, 1));
    tbl.push_back(mk(1, 1, 8'h77, 0, 16'h1234, 0,   0, 0, 1, 8'h12, 1));
    tbl.push_back(mk(1, 1, 8'h77, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h77, 0, 16'h0000, 0,   1, 0, 1, 8'h77, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
    // RF byte stalled two cycles by FIFO_FULL
    tbl.push_back(mk(1, 1, 8'h3C, 0, 16'h0000, 1,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 8'h3C, 0, 16'h0000, 1,   1, 0, 0, 8'h3C, 1));
    tbl.push_back(mk(1, 0, 8'h3C, 0, 16'h0000, 1,   0, 0, 0, 8'h3C, 1));
    tbl.push_back(mk(1, 0, 8'h3C, 0, 16'h0000, 0,   0, 0, 1, 8'h3C, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
    // RF request raised and dropped mid-packet is never granted
    tbl.push_back(mk(1, 0, 8'h00, 1, 16'h1234, 0,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 1, 8'h99, 0, 16'h1234, 0,   0, 1, 1, 8'h34, 1));
    tbl.push_back(mk(1, 0, 8'h99, 0, 16'h0000, 0,   0, 0, 1, 8'h12, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // ALU ABCD: low byte written, high byte stalled 5 cycles, then one write
    apply(mk(1, 0, 8'h00, 1, 16'hABCD, 0,   0, 0, 0, 8'h00, 0), 100);
    apply(mk(1, 0, 8'h00, 0, 16'hABCD, 0,   0, 1, 1, 8'hCD, 1), 101);
    for (int i = 0; i < 5; i++)
      apply(mk(1, 0, 8'h00, 0, 16'h0000, 1, 0, 0, 0, 8'hAB, 1), 102 + i);
    apply(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 1, 8'hAB, 1), 107);
    apply(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0), 108);

    // reset while in SEND_HI: high byte is discarded
    apply(mk(1, 0, 8'h00, 1, 16'hABCD, 0,   0, 0, 0, 8'h00, 0), 200);
    apply(mk(1, 0, 8'h00, 0, 16'hABCD, 0,   0, 1, 1, 8'hCD, 1), 201);
    apply(mk(0, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'hAB, 1), 202);
    apply(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0), 203);
    apply(mk(1, 0, 8'h00, 0, 16'h0000, 0,   0, 0, 0, 8'h00, 0), 204);

    // FIFO byte stream
    exp_q = '{8'h5A, 8'h34, 8'h12, 8'h5A, 8'h34, 8'h12, 8'h77, 8'h3C,
              8'h34, 8'h12, 8'hCD, 8'hAB, 8'hCD};
    chk("fifo_count", 300, 16'(got_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk("fifo_byte", 300 + i, 16'(got_q[i]), 16'(exp_q[i]));
      else                  chk("fifo_byte", 300 + i, 16'hFFFF, 16'(exp_q[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
